// File: rtl/divider_if.sv
// divider_if: request/response bundle between the execute stage and the
// iterative divider.
//
// Handshake: an operation transfers on a rising clock edge where div_valid
// and div_ready are both 1 and div_cancel is 0. The requester holds
// div_valid and its operands until it sees div_ready. div_ready depends only
// on divider state. complete is a one-cycle pulse, and s/r are valid while
// it is high. s/r then hold until the next completion. div_cancel aborts
// whatever is in flight on the next edge.
//
// Signals:
//   div_valid   requester -> divider  operation request
//   div_signed  requester -> divider  1 = DIV (two's complement), 0 = DIVU
//   x, y        requester -> divider  dividend, divisor
//   div_cancel  requester -> divider  flush
//   div_ready   divider -> requester  idle, can accept
//   complete    divider -> requester  result pulse
//   s, r        divider -> requester  quotient (LO), remainder (HI)
//   dbg_state   divider -> requester  FSM state, for observation only
interface divider_if;
  logic        div_valid;
  logic        div_signed;
  logic [31:0] x;
  logic [31:0] y;
  logic        div_cancel;
  logic        div_ready;
  logic        complete;
  logic [31:0] s;
  logic [31:0] r;
  logic [1:0]  dbg_state;

  modport master (
    output div_valid, div_signed, x, y, div_cancel,
    input  div_ready, complete, s, r, dbg_state
  );

  modport slave (
    input  div_valid, div_signed, x, y, div_cancel,
    output div_ready, complete, s, r, dbg_state
  );
endinterface

// File: rtl/divider.sv
// divider: iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
// The divider computes one quotient bit per cycle on operand magnitudes,
// then applies the sign fix when it registers the result.
// Latency is 33 cycles from accept to complete. Throughput is one operation
// per 34 cycles.
//
// Ports:
//   clk    clock, rising edge
//   reset  synchronous, active-high
//   bus    divider_if.slave (request, cancel, ready, complete, s, r, dbg_state)
module divider (
  input logic      clk,
  input logic      reset,
  divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  count;
  // Dividend shift register. Dividend bits leave at the MSB and quotient
  // bits enter at the LSB, so it holds the full quotient after 32 steps.
  logic [31:0] dvd;
  logic [31:0] dvs;        // |y|
  logic [32:0] rem;        // partial remainder
  logic        neg_q;      // operand signs differ (signed mode only)
  logic        neg_r;      // dividend negative (signed mode only)
  logic        dvs_zero;
  logic        complete_q;
  logic [31:0] s_q;
  logic [31:0] r_q;

  // Operand magnitudes at accept time.
  logic        x_neg;
  logic        y_neg;
  logic [31:0] abs_x;
  logic [31:0] abs_y;

  // One restoring step.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        take;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] s_fix;
  logic [31:0] r_fix;

  always_comb begin
    x_neg = bus.div_signed & bus.x[31];
    y_neg = bus.div_signed & bus.y[31];
    abs_x = x_neg ? (32'd0 - bus.x) : bus.x;
    abs_y = y_neg ? (32'd0 - bus.y) : bus.y;
  end

  always_comb begin
    shifted  = {rem[31:0], dvd[31]};
    diff     = shifted - {1'b0, dvs};
    // The partial remainder is always below 2*|y|, so a 33-bit difference
    // cannot overflow and bit 32 is a valid sign.
    take     = ~diff[32];
    rem_next = take ? diff : shifted;
    quo_next = {dvd[30:0], take};
    // A zero divisor yields an all-ones quotient whatever the signs. The
    // remainder comes out as x because the magnitude path returns |x| and the
    // sign fix restores the dividend's sign.
    if (dvs_zero) begin
      s_fix = 32'hFFFF_FFFF;
    end else begin
      s_fix = neg_q ? (32'd0 - quo_next) : quo_next;
    end
    r_fix = neg_r ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 5'd0;
      dvd        <= 32'd0;
      dvs        <= 32'd0;
      rem        <= 33'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      dvs_zero   <= 1'b0;
      complete_q <= 1'b0;
      s_q        <= 32'd0;
      r_q        <= 32'd0;
    end else begin
      complete_q <= 1'b0;
      if (bus.div_cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.div_valid) begin
              dvd      <= abs_x;
              dvs      <= abs_y;
              neg_q    <= x_neg ^ y_neg;
              neg_r    <= x_neg;
              dvs_zero <= (bus.y == 32'd0);
              rem      <= 33'd0;
              count    <= 5'd0;
              state    <= BUSY;
            end
          end
          BUSY: begin
            rem   <= rem_next;
            dvd   <= quo_next;
            count <= count + 5'd1;
            if (count == 5'd31) begin
              state      <= DONE;
              s_q        <= s_fix;
              r_q        <= r_fix;
              complete_q <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.div_ready = (state == IDLE);
  assign bus.complete  = complete_q;
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/divider.md
# divider

Iterative 32-bit radix-2 restoring divider for the execute stage, serving MIPS DIV and DIVU. It is the inverse-operation partner of the Booth/Wallace multiplier path and writes HI/LO the same way. The divider accepts one operation per handshake, computes one quotient bit per cycle, and pulses `complete` with registered quotient and remainder. An exception flush can abort an operation in flight.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `div_valid`  in  1  operation request; operands valid this cycle.
- `div_signed`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `x`  in  32  dividend.
- `y`  in  32  divisor.
- `div_cancel`  in  1  flush; aborts any operation in progress.
- `div_ready`  out  1  divider idle, can accept; combinational from state only.
- `complete`  out  1  one-cycle pulse; `s`/`r` valid this cycle.
- `s`  out  32  quotient (to LO).
- `r`  out  32  remainder (to HI).

## Operation
- States:
  - IDLE: `div_ready`=1.
  - BUSY: 5-bit counter, 0..31.
  - DONE: `complete`=1.
- Accept: IDLE, `div_valid`=1, `div_cancel`=0.
  - Latch |x|, |y|, sign of x, and sign of x XOR sign of y. Absolute values apply only when `div_signed`=1.
  - Clear the 33-bit partial remainder and counter. Move to BUSY.
- BUSY step:
  - Shift the next dividend MSB into the partial remainder.
  - Trial-subtract |y| with a 33-bit subtract.
  - If the result is non-negative: keep the difference and set quotient bit 1. Otherwise restore and set bit 0.
  - Counter increments. After step 31 the state moves to DONE and the final `s`/`r` are registered.
- Sign fix, applied when registering results in signed mode:
  - `s` is negated if the operand signs differ.
  - `r` is negated if x was negative. Remainder sign follows the dividend.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives `s`=0x80000000, `r`=0. This is natural 32-bit wrap with no flag.
- Divide by zero, either mode: `s`=0xFFFFFFFF, `r`=x. Full latency still applies.
- DONE: `complete`=1 for exactly one cycle, then IDLE.
- `s`/`r` hold their value until the next DONE. They are not cleared on accept or cancel.
- Cancel:
  - `div_cancel`=1 in any state: next edge goes to IDLE.
  - No `complete` is issued for the aborted operation.
  - Cancel wins over a simultaneous accept. It also suppresses a pending DONE pulse: if asserted in the DONE cycle, `complete` is still high that cycle but the state returns to IDLE, which matches normal flow.
- `div_valid` while BUSY/DONE is ignored. The requester holds `div_valid` until it sees `div_ready`.

## Timing
- Reset values: state IDLE, `div_ready`=1, `complete`=0, `s`=0, `r`=0, counter 0.
- Reset mid-operation: next edge gives IDLE, no `complete`, `s`/`r` cleared to 0.
- Accept sampled at edge E0. BUSY occupies cycles after E0..E32. `complete`=1 in the cycle after edge E32, which is 33 cycles after accept.
- `div_ready`=0 from the cycle after E0 through the DONE cycle inclusive.
- Back-to-back: next accept possible in the cycle after DONE. Throughput is one operation per 34 cycles.
- No combinational path from `x`/`y`/`div_valid` to any output.

## Test plan
- DIVU x=100, y=7, accepted at E0 → `complete` in the cycle after E32 with `s`=14, `r`=2. `div_ready`=0 for exactly 33 cycles.
- DIV x=0xFFFFFFF9 (-7), y=2 → `s`=0xFFFFFFFD, `r`=0xFFFFFFFF. Also DIV 7/-2 → `s`=0xFFFFFFFD, `r`=1. Also DIVU 0xFFFFFFF9/2 → `s`=0x7FFFFFFC, `r`=1.
- DIV 0x80000000 / 0xFFFFFFFF → `s`=0x80000000, `r`=0. DIVU x=0x1234, y=0 → `s`=0xFFFFFFFF, `r`=0x1234.
- Cancel: accept 100/7, assert `div_cancel` at cycle E0+10 → IDLE next cycle, no `complete`, `s`/`r` unchanged. Then accept 9/3 → `s`=3, `r`=0 after 33 cycles.
- Cancel and `div_valid` together in IDLE → not accepted, `div_ready` stays 1.
- Reset at E0+20 of an operation → all outputs at reset values next cycle, no `complete`. A subsequent DIVU 0xFFFFFFFF/1 → `s`=0xFFFFFFFF, `r`=0.
